// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic {
        MD_OP_MUL = 1'b0,
        MD_OP_DIV = 1'b1
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam int unsigned MD_MUL_BITS_MAX = 8;

    // Legal radix: a power of two no larger than MD_MUL_BITS_MAX that divides the width.
    function automatic bit md_mul_bits_ok(input int unsigned mul_bits, input int unsigned width);
        return (mul_bits != 0) && (mul_bits <= MD_MUL_BITS_MAX) &&
               ((mul_bits & (mul_bits - 1)) == 0) && ((width % mul_bits) == 0);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EXE stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             is_signed;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, is_signed, src1, src2, cancel,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, is_signed, src1, src2, cancel,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of two words, either independently
// or as one double-width value (used for the 2*WIDTH product).
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             join_halves,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic [WIDTH-1:0] in_hi,
    input  logic [WIDTH-1:0] in_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);
    logic [1:0][WIDTH-1:0] lane_in;
    logic [1:0][WIDTH-1:0] lane_out;
    logic [1:0]            lane_neg;
    logic [2*WIDTH-1:0]    wide_neg;

    assign lane_in  = {in_hi, in_lo};
    assign lane_neg = {neg_hi, neg_lo};
    assign wide_neg = -{in_hi, in_lo};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_out[gi] = lane_neg[gi] ? -lane_in[gi] : lane_in[gi];
        end
    endgenerate

    // Joined mode negates across the halves so the borrow propagates into hi.
    always_comb begin
        if (join_halves) begin
            {out_hi, out_lo} = neg_lo ? wide_neg : {in_hi, in_lo};
        end else begin
            out_hi = lane_out[1];
            out_lo = lane_out[0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; otherwise divides complete at once with no effect on HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int MUL_STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W     = $clog2(WIDTH) + 1;

    generate
        if (!md_mul_bits_ok(MUL_BITS, WIDTH)) begin : g_bad_cfg
            $error("muldiv_unit: illegal MUL_BITS for this WIDTH");
        end
    endgenerate

    md_state_e          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic               prod_neg_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               dbz_reg;

    logic               accept, req_div, div_fast, last_step;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   raw_hi, raw_lo, fix_hi, fix_lo;
    logic               out_join, out_neg_hi;
    logic [2*WIDTH-1:0] step_acc_next;

    logic [WIDTH+MUL_BITS-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_acc_next;

    assign accept  = (state_reg == ST_IDLE) && bus.start && !bus.cancel;
    assign req_div = (bus.op == MD_OP_DIV);

    muldiv_signfix #(.WIDTH(WIDTH)) u_in_fix (
        .join_halves (1'b0),
        .neg_hi      (bus.is_signed & bus.src1[WIDTH-1]),
        .neg_lo      (bus.is_signed & bus.src2[WIDTH-1]),
        .in_hi       (bus.src1),
        .in_lo       (bus.src2),
        .out_hi      (mag1),
        .out_lo      (mag2)
    );

    // One radix-2^MUL_BITS digit of the multiplier per step; the sum cannot overflow WIDTH+MUL_BITS.
    assign mul_sum = {{MUL_BITS{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]}
                   + ((WIDTH+MUL_BITS)'(opb_reg) * (WIDTH+MUL_BITS)'(acc_reg[MUL_BITS-1:0]));
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:MUL_BITS]};

`ifdef MULDIV_DIV_EN
    md_op_e           op_reg;
    logic             rem_neg_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] div_rem_next, div_quo_next;

    // The dividend shifts out of acc_reg's low half while quotient bits shift in.
    assign div_shift    = {rem_reg, acc_reg[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, opb_reg};
    assign div_fits     = ~div_diff[WIDTH];
    assign div_rem_next = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_next = {acc_reg[WIDTH-2:0], div_fits};

    assign div_fast      = req_div && (bus.src2 == '0);
    assign last_step     = (op_reg == MD_OP_DIV) ? (cnt_reg == CNT_W'(WIDTH - 1))
                                                 : (cnt_reg == CNT_W'(MUL_STEPS - 1));
    assign step_acc_next = (op_reg == MD_OP_DIV) ? {acc_reg[2*WIDTH-1:WIDTH], div_quo_next}
                                                 : mul_acc_next;
    assign raw_hi        = (op_reg == MD_OP_DIV) ? div_rem_next : mul_acc_next[2*WIDTH-1:WIDTH];
    assign raw_lo        = (op_reg == MD_OP_DIV) ? div_quo_next : mul_acc_next[WIDTH-1:0];
    assign out_join      = (op_reg == MD_OP_MUL);
    assign out_neg_hi    = rem_neg_reg;
`else
    assign div_fast      = req_div;
    assign last_step     = (cnt_reg == CNT_W'(MUL_STEPS - 1));
    assign step_acc_next = mul_acc_next;
    assign raw_hi        = mul_acc_next[2*WIDTH-1:WIDTH];
    assign raw_lo        = mul_acc_next[WIDTH-1:0];
    assign out_join      = 1'b1;
    assign out_neg_hi    = 1'b0;
`endif

    muldiv_signfix #(.WIDTH(WIDTH)) u_out_fix (
        .join_halves (out_join),
        .neg_hi      (out_neg_hi),
        .neg_lo      (prod_neg_reg),
        .in_hi       (raw_hi),
        .in_lo       (raw_lo),
        .out_hi      (fix_hi),
        .out_lo      (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (accept) state_next = div_fast ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (bus.cancel)     state_next = ST_IDLE;
                else if (last_step) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_reg != ST_IDLE);
        bus.done        = (state_reg == ST_DONE);
        bus.hi          = hi_reg;
        bus.lo          = lo_reg;
        bus.div_by_zero = dbz_reg;
    end

    // Results land only on the edge entering DONE; a cancel on that edge suppresses them.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            prod_neg_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            dbz_reg      <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_reg       <= MD_OP_MUL;
            rem_neg_reg  <= 1'b0;
            rem_reg      <= '0;
`endif
        end else if (accept) begin
            cnt_reg      <= '0;
            acc_reg      <= {{WIDTH{1'b0}}, req_div ? mag1 : mag2};
            opb_reg      <= req_div ? mag2 : mag1;
            prod_neg_reg <= bus.is_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            op_reg       <= md_op_e'(bus.op);
            rem_neg_reg  <= bus.is_signed & bus.src1[WIDTH-1];
            rem_reg      <= '0;
            if (div_fast) begin
                hi_reg  <= bus.src1;
                lo_reg  <= '1;
                dbz_reg <= 1'b1;
            end
`else
            if (div_fast) begin
                dbz_reg <= 1'b0;
            end
`endif
        end else if ((state_reg == ST_CALC) && !bus.cancel) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            acc_reg <= step_acc_next;
`ifdef MULDIV_DIV_EN
            rem_reg <= div_rem_next;
`endif
            if (last_step) begin
                hi_reg  <= fix_hi;
                lo_reg  <= fix_lo;
                dbz_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: radix-1 and radix-4 units share one stimulus stream and a
// cycle-count/arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         is_signed = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    bit           cmp_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus1 ();
    muldiv_if #(.WIDTH(W)) bus2 ();

    assign bus1.start = start;  assign bus2.start = start;
    assign bus1.op = op;        assign bus2.op = op;
    assign bus1.is_signed = is_signed; assign bus2.is_signed = is_signed;
    assign bus1.src1 = src1;    assign bus2.src1 = src1;
    assign bus1.src2 = src2;    assign bus2.src2 = src2;
    assign bus1.cancel = cancel; assign bus2.cancel = cancel;

    muldiv_unit #(.WIDTH(W), .MUL_BITS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    muldiv_unit #(.WIDTH(W), .MUL_BITS(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic; lat is the cycle index in which done must pulse.
    function automatic void calc(input logic o, input logic sg, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int mul_lat,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl,
                                 output bit rdbz, output bit rwr, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        rh = '0; rl = '0; rdbz = 1'b0; rwr = 1'b1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o == 1'b0) begin
            lat = mul_lat;
            if (sg) p = sa * sb;
            else    p = ua * ub;
            rh = p[63:32];
            rl = p[31:0];
        end else if (!DIV_EN) begin
            lat = 0;
            rwr = 1'b0;
        end else if (b == '0) begin
            lat = 0; rh = a; rl = '1; rdbz = 1'b1;
        end else begin
            lat = W;
            if (sg) begin q = sa / sb; r = sa % sb; end
            else begin q = longint'(ua / ub); r = longint'(ua % ub); end
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    bit           m_active[2];
    int           m_left[2];
    logic [W-1:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
    bit           m_dbz[2], p_dbz[2], p_wr[2];
    logic [W-1:0] t_hi, t_lo;
    bit           t_dbz, t_wr;
    int           t_lat;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                m_active[u] <= 1'b0; m_left[u] <= 0;
                m_hi[u] <= '0; m_lo[u] <= '0; m_dbz[u] <= 1'b0;
            end else if (m_active[u]) begin
                if (cancel || m_left[u] == 0) begin
                    m_active[u] <= 1'b0;
                end else begin
                    m_left[u] <= m_left[u] - 1;
                    if (m_left[u] == 1) begin
                        if (p_wr[u]) begin m_hi[u] <= p_hi[u]; m_lo[u] <= p_lo[u]; end
                        m_dbz[u] <= p_dbz[u];
                    end
                end
            end else if (start && !cancel) begin
                calc(op, is_signed, src1, src2, (u == 0) ? 32 : 8, t_hi, t_lo, t_dbz, t_wr, t_lat);
                m_active[u] <= 1'b1;
                m_left[u]   <= t_lat;
                p_hi[u] <= t_hi; p_lo[u] <= t_lo; p_dbz[u] <= t_dbz; p_wr[u] <= t_wr;
                if (t_lat == 0) begin
                    if (t_wr) begin m_hi[u] <= t_hi; m_lo[u] <= t_lo; end
                    m_dbz[u] <= t_dbz;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("u0 busy", bus1.busy, m_active[0]);
            check("u0 done", bus1.done, m_active[0] && m_left[0] == 0);
            check("u0 hi", bus1.hi, m_hi[0]);
            check("u0 lo", bus1.lo, m_lo[0]);
            check("u0 div_by_zero", bus1.div_by_zero, m_dbz[0]);
            check("u1 busy", bus2.busy, m_active[1]);
            check("u1 done", bus2.done, m_active[1] && m_left[1] == 0);
            check("u1 hi", bus2.hi, m_hi[1]);
            check("u1 lo", bus2.lo, m_lo[1]);
            check("u1 div_by_zero", bus2.div_by_zero, m_dbz[1]);
        end
    end

    task automatic issue(input logic o, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; is_signed = sg; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in cycle 0; returns the cycle of dut1's done and of dut2's first done.
    task automatic wait_done(input int budget, output int cyc, output int cyc2);
        cyc = 0; cyc2 = -1;
        forever begin
            if (bus2.done === 1'b1 && cyc2 < 0) cyc2 = cyc;
            if (bus1.done === 1'b1 || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
        if (bus1.done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL done timeout: no done within %0d cycles", budget);
            cyc = -1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, c2, ndone;
        logic [W-1:0] prev_hi, prev_lo;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset busy", bus1.busy, 0);
        check("reset done", bus1.done, 0);
        check("reset hi", bus1.hi, 0);
        check("reset lo", bus1.lo, 0);
        check("reset dbz", bus1.div_by_zero, 0);
        reset = 1'b0;

        issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(40, c, c2);
        check("umul done cycle", c, 32);
        check("umul r4 done cycle", c2, 8);
        check("umul hi", bus1.hi, 32'hFFFFFFFE);
        check("umul lo", bus1.lo, 32'h00000001);
        $display("umul ffffffff*ffffffff: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        issue(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7);
        wait_done(40, c, c2);
        check("smul done cycle", c, 32);
        check("smul r4 done cycle", c2, 8);
        check("smul hi", bus1.hi, 32'hFFFFFFFF);
        check("smul lo", bus1.lo, 32'hFFFFFFEB);
        check("smul r4 hi", bus2.hi, 32'hFFFFFFFF);
        check("smul r4 lo", bus2.lo, 32'hFFFFFFEB);
        $display("smul -3*7: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        issue(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(40, c, c2);
        check("sdiv done cycle", c, DIV_EN ? 32 : 0);
        check("sdiv lo", bus1.lo, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFEB);
        check("sdiv hi", bus1.hi, 32'hFFFFFFFF);
        $display("sdiv -7/2: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        issue(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(40, c, c2);
        check("ovf done cycle", c, DIV_EN ? 32 : 0);
        check("ovf lo", bus1.lo, DIV_EN ? 32'h80000000 : 32'hFFFFFFEB);
        check("ovf hi", bus1.hi, DIV_EN ? 32'h0 : 32'hFFFFFFFF);
        $display("sdiv min/-1: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        issue(1'b1, 1'b0, 32'd5, 32'd0);
        wait_done(40, c, c2);
        check("dz done cycle", c, 0);
        check("dz hi", bus1.hi, DIV_EN ? 32'd5 : 32'hFFFFFFFF);
        check("dz lo", bus1.lo, DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFEB);
        check("dz flag", bus1.div_by_zero, DIV_EN);
        $display("udiv 5/0: hi=%h lo=%h dbz=%b cycle=%0d", bus1.hi, bus1.lo, bus1.div_by_zero, c);

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(40, c, c2);
        check("udiv done cycle", c, DIV_EN ? 32 : 0);
        check("udiv lo", bus1.lo, DIV_EN ? 32'd14 : 32'hFFFFFFEB);
        check("udiv hi", bus1.hi, DIV_EN ? 32'd2 : 32'hFFFFFFFF);
        check("udiv dbz cleared", bus1.div_by_zero, 0);
        $display("udiv 100/7: hi=%h lo=%h dbz=%b cycle=%0d", bus1.hi, bus1.lo, bus1.div_by_zero, c);

        prev_hi = DIV_EN ? 32'd2 : 32'hFFFFFFFF;
        prev_lo = DIV_EN ? 32'd14 : 32'hFFFFFFEB;
        issue(1'b0, 1'b0, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", bus1.busy, 0);
        check("cancel hi kept", bus1.hi, prev_hi);
        check("cancel lo kept", bus1.lo, prev_lo);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; src1 = 32'd6; src2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("post-cancel accept busy", bus1.busy, 1);
        wait_done(40, c, c2);
        check("post-cancel done cycle", c, 32);
        check("post-cancel lo", bus1.lo, 32'd42);
        check("post-cancel hi", bus1.hi, 32'd0);
        $display("cancel then mul 6*7: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        issue(DIV_EN, 1'b0, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 1'b0; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 6; k < 46; k++) begin
            if (bus1.done === 1'b1) ndone++;
            @(negedge clk);
        end
        check("ignored start done count", ndone, 1);
        check("ignored start lo", bus1.lo, DIV_EN ? 32'd333 : 32'd3000);
        check("ignored start hi", bus1.hi, DIV_EN ? 32'd1 : 32'd0);
        $display("busy-start ignored: dones=%0d hi=%h lo=%h", ndone, bus1.hi, bus1.lo);

        issue(1'b0, 1'b0, 32'd77, 32'd88);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", bus1.busy, 0);
        check("midreset done", bus1.done, 0);
        check("midreset hi", bus1.hi, 0);
        check("midreset lo", bus1.lo, 0);
        check("midreset dbz", bus1.div_by_zero, 0);
        $display("reset mid-op: busy=%b hi=%h lo=%h", bus1.busy, bus1.hi, bus1.lo);

        issue(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(40, c, c2);
        check("neg*neg lo", bus1.lo, 32'd1);
        check("neg*neg hi", bus1.hi, 32'd0);
        $display("smul -1*-1: hi=%h lo=%h cycle=%0d", bus1.hi, bus1.lo, c);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EXE stage of the five-stage pipeline. It replaces the multiply-only helper and adds signed/unsigned division, a configurable multiply radix, and a cancel path for exception flushes. EXE raises `start` for one cycle and holds `EXE_over` low until `done`. The unit owns the architectural HI/LO result registers.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_BITS`, 1: multiplier bits retired per cycle. Legal values are 1, 2, 4, 8. `WIDTH % MUL_BITS == 0` is required.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 1: 0 = multiply, 1 = divide.
- `is_signed` in 1: 1 = two's-complement operands.
- `src1` in `WIDTH`: multiplicand or dividend.
- `src2` in `WIDTH`: multiplier or divisor.
- `cancel` in 1: abort the current or requested operation.
- `busy` out 1: high from the accept edge through the `done` cycle.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in that cycle.
- `hi` out `WIDTH`:
  - multiply: product upper half;
  - divide: remainder.
- `lo` out `WIDTH`:
  - multiply: product lower half;
  - divide: quotient.
- `div_by_zero` out 1: set with `done` for a zero divisor; holds until the next `done`.

## Operation
- States:
  - IDLE → CALC on `start & ~cancel`.
  - IDLE → DONE directly for a divide with `src2 == 0`.
  - CALC → DONE when the step counter reaches its last value.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `cancel`.
- Accept:
  - Latch `op` and `is_signed`.
  - Latch operand magnitudes: the absolute value when signed and negative, else the raw value.
  - Record the result signs:
    - product/quotient sign = s1 ^ s2;
    - remainder sign = s1.
- Multiply: shift-add, `MUL_BITS` multiplier bits per CYCLE step. The accumulator is 2×`WIDTH` bits. Steps = `WIDTH/MUL_BITS`.
- Divide: restoring, one quotient bit per step, `WIDTH` steps. The partial remainder is `WIDTH+1` bits.
- Sign restore happens combinationally on the final step. Results are registered into `hi`/`lo` at the edge that enters DONE.
- Zero divisor: `hi = src1` (raw), `lo = all ones`, `div_by_zero = 1`.
- Signed overflow (MIN / -1): `lo = MIN`, `hi = 0`. This is the natural magnitude result and needs no special case.
- `hi`/`lo`/`div_by_zero` change only on entry to DONE. A cancelled operation leaves them untouched.
- `start` is ignored while `busy` is high.
- `cancel` with `start` in the same cycle: cancel wins and nothing is accepted.
- Reset values: `busy = 0`, `done = 0`, `hi = 0`, `lo = 0`, `div_by_zero = 0`, state IDLE, counter 0.

## Timing
- Edge 0 is the accept edge; cycle k is the period following edge k.
- Multiply:
  - results written at edge `WIDTH/MUL_BITS`;
  - `done` high in cycle `WIDTH/MUL_BITS` (32 for the defaults).
- Divide:
  - results written at edge `WIDTH`;
  - `done` high in cycle `WIDTH`.
- Zero-divisor divide: `done` in cycle 0.
- `busy` covers cycles 0 through the `done` cycle. The earliest next accept is the edge ending the `done` cycle.
- Cancel asserted in cycle k: `busy = 0` in cycle k+1, and `done` never pulses for that operation.
- Reset asserted mid-operation behaves like a cancel, but also clears `hi`/`lo`.

## Configuration
- `MULDIV_DIV_EN` defined: full divider as above.
- `MULDIV_DIV_EN` undefined:
  - divider datapath and remainder register are removed;
  - a divide request is accepted and completes in cycle 0 with `done = 1`;
  - `hi`/`lo` are unchanged;
  - `div_by_zero = 0`.

## Structure
- Package `muldiv_pkg`:
  - `op` encodings: `MD_OP_MUL`, `MD_OP_DIV`;
  - state enum: IDLE/CALC/DONE;
  - legal `MUL_BITS` check constant.
- Sub-module `muldiv_signfix`: combinational conversion of inputs to absolute values and restoration of result signs. It is instantiated once for inputs and once for outputs.
- Counter width is `$clog2(WIDTH)+1`.

## Test plan
1. Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → `hi = 0xFFFFFFFE`, `lo = 0x00000001`, `done` in cycle 32, `busy` cycles 0–32.
2. Signed multiply −3 × 7 → `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFEB`. Repeat with `MUL_BITS = 4` → same result, `done` in cycle 8.
3. Signed divide −7 / 2 → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. Signed 0x80000000 / 0xFFFFFFFF → `lo = 0x80000000`, `hi = 0`. Both have `done` in cycle 32.
4. Divide 5 / 0 → `done` in cycle 0, `hi = 5`, `lo = 0xFFFFFFFF`, `div_by_zero = 1`. The following valid divide clears `div_by_zero`.
5. Multiply with `cancel` in cycle 10 → `busy = 0` in cycle 11, no `done`, `hi`/`lo` keep prior values. A new `start` in cycle 11 is accepted normally.
6. `start` pulsed in cycle 5 of a busy divide → ignored, only one `done`. Reset in cycle 20 → all outputs 0 in the next cycle.
